// File: rtl/wb_pkg.sv
// Shared types and the round-robin selection function for Wishbone arbiters.
// rr_pick supports up to RR_MAX requesters; callers zero-extend their vectors.
package wb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DRAIN} arb_state_t;

  localparam int RR_MAX = 16;
  localparam int RR_IW  = 4;

  // Scan ptr+1, ptr+2, ... modulo n and return the first requester as one-hot.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [RR_IW-1:0]  ptr,
                                                input logic [RR_IW:0]    n);
    logic [RR_MAX-1:0] pick;
    logic [RR_IW:0]    idx;
    logic              found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = {1'b0, ptr} + (RR_IW+1)'(k);
      if (idx >= n) idx = idx - n;
      if (!found && ((RR_IW+1)'(k) <= n) && req[idx[RR_IW-1:0]]) begin
        pick[idx[RR_IW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Master-side bundle (N masters, packed) and single slave-side Wishbone bus.
// Each has a master modport (drives requests) and a slave modport (answers them).
interface wb_mst_if #(
  parameter int N_MST  = 4,
  parameter int BW_ADR = 8,
  parameter int BW_DAT = 8,
  parameter int BW_SEL = 1
);
  logic [N_MST-1:0]        m_cyc;
  logic [N_MST-1:0]        m_stb;
  logic [N_MST-1:0]        m_we;
  logic [N_MST-1:0]        m_tagn_w;
  logic [N_MST*BW_ADR-1:0] m_adr;
  logic [N_MST*BW_DAT-1:0] m_dat_w;
  logic [N_MST*BW_SEL-1:0] m_sel;
  logic [BW_DAT-1:0]       m_dat_r;
  logic                    m_tagn_r;
  logic [N_MST-1:0]        m_ack;
  logic [N_MST-1:0]        m_err;
  logic [N_MST-1:0]        gnt;

  modport master (output m_cyc, m_stb, m_we, m_tagn_w, m_adr, m_dat_w, m_sel,
                  input  m_dat_r, m_tagn_r, m_ack, m_err, gnt);
  modport slave  (input  m_cyc, m_stb, m_we, m_tagn_w, m_adr, m_dat_w, m_sel,
                  output m_dat_r, m_tagn_r, m_ack, m_err, gnt);
endinterface

interface wb_slv_if #(
  parameter int BW_ADR = 8,
  parameter int BW_DAT = 8,
  parameter int BW_SEL = 1
);
  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic              s_tagn_w;
  logic [BW_ADR-1:0] s_adr;
  logic [BW_DAT-1:0] s_dat_w;
  logic [BW_SEL-1:0] s_sel;
  logic [BW_DAT-1:0] s_dat_r;
  logic              s_ack;
  logic              s_tagn_r;

  modport master (output s_cyc, s_stb, s_we, s_tagn_w, s_adr, s_dat_w, s_sel,
                  input  s_dat_r, s_ack, s_tagn_r);
  modport slave  (input  s_cyc, s_stb, s_we, s_tagn_w, s_adr, s_dat_w, s_sel,
                  output s_dat_r, s_ack, s_tagn_r);
endinterface

// File: rtl/wb_rr_arbiter_picker.sv
// Combinational round-robin picker: first requester after i_ptr, as one-hot and index.
// Zero latency, no state; o_vld low means nothing requested.
module wb_rr_picker
  import wb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_vld,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic [RR_MAX-1:0] w_pick;

  assign w_pick   = rr_pick(RR_MAX'(i_req), RR_IW'(i_ptr), (RR_IW+1)'(N));
  assign o_onehot = N'(w_pick);
  assign o_vld    = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (o_onehot[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one-cycle arbitration, grant held until the owner drops cyc.
// Stalls are bounded by a watchdog that errors the owner and drains its cycle.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MST       = 4,
  parameter int BW_ADR      = 8,
  parameter int BW_DAT      = 8,
  parameter int GRANULARITY = 8,
  parameter int TIMEOUT     = 255
) (
  input logic      wb_clk,
  input logic      wb_rst,
  wb_mst_if.slave  mst,
  wb_slv_if.master slv
);

  localparam int BW_SEL = BW_DAT / GRANULARITY;
  localparam int IW     = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int WDW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0]  PTR_RST = IW'(N_MST - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       r_state;
  logic [N_MST-1:0] r_gnt;
  logic [IW-1:0]    r_ptr;
  logic [WDW-1:0]   r_wdog;

  logic [BW_ADR-1:0] w_adr [N_MST];
  logic [BW_DAT-1:0] w_dat [N_MST];
  logic [BW_SEL-1:0] w_sel [N_MST];

  logic             w_pick_vld;
  logic [N_MST-1:0] w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_busy;
  logic             w_cyc_g;
  logic             w_stb_g;
  logic             w_stall;
  logic             w_timeout;

  for (genvar i = 0; i < N_MST; i++) begin : g_unpack
    assign w_adr[i] = mst.m_adr[i*BW_ADR +: BW_ADR];
    assign w_dat[i] = mst.m_dat_w[i*BW_DAT +: BW_DAT];
    assign w_sel[i] = mst.m_sel[i*BW_SEL +: BW_SEL];
  end

  wb_rr_picker #(.N(N_MST)) u_picker (
    .i_req    (mst.m_cyc),
    .i_ptr    (r_ptr),
    .o_vld    (w_pick_vld),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  // r_ptr doubles as the granted master's index for the whole tenure.
  assign w_busy    = (r_state == ARB_BUSY);
  assign w_cyc_g   = mst.m_cyc[r_ptr];
  assign w_stb_g   = mst.m_stb[r_ptr];
  assign w_stall   = w_busy & w_cyc_g & w_stb_g & ~slv.s_ack;
  assign w_timeout = (TIMEOUT > 0) && w_stall && (r_wdog == WD_LAST);

  assign mst.m_dat_r  = slv.s_dat_r;
  assign mst.m_tagn_r = slv.s_tagn_r;
  assign mst.gnt      = r_gnt;

  always_comb begin
    slv.s_cyc    = 1'b0;
    slv.s_stb    = 1'b0;
    slv.s_we     = 1'b0;
    slv.s_tagn_w = 1'b0;
    slv.s_adr    = '0;
    slv.s_dat_w  = '0;
    slv.s_sel    = '0;
    mst.m_ack    = '0;
    mst.m_err    = '0;
    if (w_busy) begin
      slv.s_cyc           = w_cyc_g;
      slv.s_stb           = w_stb_g;
      slv.s_we            = mst.m_we[r_ptr];
      slv.s_tagn_w        = mst.m_tagn_w[r_ptr];
      slv.s_adr           = w_adr[r_ptr];
      slv.s_dat_w         = w_dat[r_ptr];
      slv.s_sel           = w_sel[r_ptr];
      mst.m_ack[r_ptr]    = slv.s_ack & w_stb_g;
      mst.m_err[r_ptr]    = w_timeout;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_RST;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_wdog <= '0;
          if (w_pick_vld) begin
            r_gnt   <= w_pick_oh;
            r_ptr   <= w_pick_idx;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A dropped cyc outranks a coincident timeout.
          if (!w_cyc_g) begin
            r_gnt   <= '0;
            r_wdog  <= '0;
            r_state <= ARB_IDLE;
          end else if (w_timeout) begin
            r_wdog  <= '0;
            r_state <= ARB_DRAIN;
          end else if (w_stall && TIMEOUT > 0) begin
            r_wdog <= r_wdog + 1'b1;
          end else begin
            r_wdog <= '0;
          end
        end
        ARB_DRAIN: begin
          r_wdog <= '0;
          if (!w_cyc_g) begin
            r_gnt   <= '0;
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= '0;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: four masters, 8-bit bus, watchdog TIMEOUT=4.
module tb_wb_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_mst_if #(.N_MST(4), .BW_ADR(8), .BW_DAT(8), .BW_SEL(1)) mif ();
  wb_slv_if #(.BW_ADR(8), .BW_DAT(8), .BW_SEL(1)) sif ();

  wb_rr_arbiter #(
    .N_MST(4), .BW_ADR(8), .BW_DAT(8), .GRANULARITY(8), .TIMEOUT(4)
  ) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .mst    (mif.slave),
    .slv    (sif.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    mif.m_cyc    = '0;
    mif.m_stb    = '0;
    mif.m_we     = '0;
    mif.m_tagn_w = '0;
    mif.m_adr    = '0;
    mif.m_dat_w  = '0;
    mif.m_sel    = '0;
    sif.s_dat_r  = '0;
    sif.s_ack    = 1'b0;
    sif.s_tagn_r = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", mif.gnt); end
    n_cmp++; if (sif.s_cyc !== 1'b0) begin n_err++; $display("FAIL reset_s_cyc got=%b exp=0", sif.s_cyc); end
    n_cmp++; if (mif.m_ack !== 4'b0000) begin n_err++; $display("FAIL reset_m_ack got=%b exp=0000", mif.m_ack); end
    n_cmp++; if (mif.m_err !== 4'b0000) begin n_err++; $display("FAIL reset_m_err got=%b exp=0000", mif.m_err); end
  endtask

  task automatic test_single_write();
    mif.m_cyc = 4'b0001; mif.m_stb = 4'b0001; mif.m_we = 4'b0001; mif.m_sel = 4'b0001;
    mif.m_adr = 32'h0000_0010; mif.m_dat_w = 32'h0000_00A5;
    #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL sw_latency got=%b exp=0000", mif.gnt); end
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0001) begin n_err++; $display("FAIL sw_gnt got=%b exp=0001", mif.gnt); end
    n_cmp++; if (sif.s_adr !== 8'h10) begin n_err++; $display("FAIL sw_adr got=%h exp=10", sif.s_adr); end
    n_cmp++; if (sif.s_dat_w !== 8'hA5) begin n_err++; $display("FAIL sw_dat got=%h exp=a5", sif.s_dat_w); end
    n_cmp++; if ({sif.s_cyc, sif.s_stb, sif.s_we} !== 3'b111) begin n_err++; $display("FAIL sw_ctl got=%b exp=111", {sif.s_cyc, sif.s_stb, sif.s_we}); end
    tick(); #1;
    n_cmp++; if (mif.m_ack !== 4'b0000) begin n_err++; $display("FAIL sw_early_ack got=%b exp=0000", mif.m_ack); end
    tick(); sif.s_ack = 1'b1; #1;
    n_cmp++; if (mif.m_ack !== 4'b0001) begin n_err++; $display("FAIL sw_ack got=%b exp=0001", mif.m_ack); end
    tick(); sif.s_ack = 1'b0; mif.m_cyc = '0; mif.m_stb = '0; #1;
    n_cmp++; if (sif.s_cyc !== 1'b0) begin n_err++; $display("FAIL sw_drop_s_cyc got=%b exp=0", sif.s_cyc); end
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL sw_release got=%b exp=0000", mif.gnt); end
  endtask

  task automatic test_all_four();
    logic [3:0] m;
    do_reset();
    mif.m_cyc = 4'hF; mif.m_stb = 4'hF; mif.m_we = 4'h0;
    mif.m_adr = {8'h23, 8'h22, 8'h21, 8'h20};
    for (int k = 0; k < 4; k++) begin
      m = 4'(1 << k);
      tick(); #1;
      n_cmp++; if (mif.gnt !== m) begin n_err++; $display("FAIL a4_gnt k=%0d got=%b exp=%b", k, mif.gnt, m); end
      n_cmp++; if (sif.s_adr !== 8'(32 + k)) begin n_err++; $display("FAIL a4_adr k=%0d got=%h exp=%h", k, sif.s_adr, 8'(32 + k)); end
      sif.s_ack = 1'b1; sif.s_dat_r = 8'(192 + k); #1;
      n_cmp++; if (mif.m_ack !== m) begin n_err++; $display("FAIL a4_ack k=%0d got=%b exp=%b", k, mif.m_ack, m); end
      n_cmp++; if (mif.m_dat_r !== 8'(192 + k)) begin n_err++; $display("FAIL a4_dat_r k=%0d got=%h exp=%h", k, mif.m_dat_r, 8'(192 + k)); end
      tick(); sif.s_ack = 1'b0; mif.m_cyc = mif.m_cyc & ~m; mif.m_stb = mif.m_stb & ~m; #1;
      n_cmp++; if (sif.s_cyc !== 1'b0) begin n_err++; $display("FAIL a4_drop k=%0d got=%b exp=0", k, sif.s_cyc); end
      tick(); #1;
      n_cmp++; if ({mif.gnt, sif.s_cyc} !== 5'b0) begin n_err++; $display("FAIL a4_gap k=%0d gnt=%b s_cyc=%b exp=0", k, mif.gnt, sif.s_cyc); end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] e;
    mif.m_cyc = 4'b1010; mif.m_stb = 4'b1010;
    for (int r = 0; r < 4; r++) begin
      e = (r % 2 == 0) ? 4'b0010 : 4'b1000;
      tick(); #1;
      n_cmp++; if (mif.gnt !== e) begin n_err++; $display("FAIL alt_gnt r=%0d got=%b exp=%b", r, mif.gnt, e); end
      sif.s_ack = 1'b1; #1;
      n_cmp++; if (mif.m_ack !== e) begin n_err++; $display("FAIL alt_ack r=%0d got=%b exp=%b", r, mif.m_ack, e); end
      tick(); sif.s_ack = 1'b0; mif.m_cyc = mif.m_cyc & ~e; mif.m_stb = mif.m_stb & ~e;
      tick(); #1;
      n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL alt_gap r=%0d got=%b exp=0000", r, mif.gnt); end
      mif.m_cyc = mif.m_cyc | e; mif.m_stb = mif.m_stb | e;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mif.m_cyc = 4'b0100; mif.m_stb = 4'b0100; mif.m_we = 4'b0100;
    tick();
    for (int s = 1; s <= 3; s++) begin
      #1;
      n_cmp++; if (mif.m_err !== 4'b0000) begin n_err++; $display("FAIL to_early_err s=%0d got=%b exp=0000", s, mif.m_err); end
      tick();
    end
    #1;
    n_cmp++; if (mif.m_err !== 4'b0100) begin n_err++; $display("FAIL to_err got=%b exp=0100", mif.m_err); end
    n_cmp++; if (mif.m_ack !== 4'b0000) begin n_err++; $display("FAIL to_ack got=%b exp=0000", mif.m_ack); end
    tick(); #1;
    n_cmp++; if ({sif.s_cyc, sif.s_stb} !== 2'b00) begin n_err++; $display("FAIL to_drain_s got=%b exp=00", {sif.s_cyc, sif.s_stb}); end
    n_cmp++; if (mif.m_err !== 4'b0000) begin n_err++; $display("FAIL to_pulse_len got=%b exp=0000", mif.m_err); end
    n_cmp++; if (mif.gnt !== 4'b0100) begin n_err++; $display("FAIL to_drain_gnt got=%b exp=0100", mif.gnt); end
    mif.m_cyc = '0; mif.m_stb = '0;
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL to_release got=%b exp=0000", mif.gnt); end
  endtask

  task automatic test_ack_on_timeout();
    do_reset();
    mif.m_cyc = 4'b0100; mif.m_stb = 4'b0100;
    tick(); tick(); tick(); tick();
    sif.s_ack = 1'b1; #1;
    n_cmp++; if (mif.m_ack !== 4'b0100) begin n_err++; $display("FAIL at_ack got=%b exp=0100", mif.m_ack); end
    n_cmp++; if (mif.m_err !== 4'b0000) begin n_err++; $display("FAIL at_err got=%b exp=0000", mif.m_err); end
    tick(); sif.s_ack = 1'b0; #1;
    n_cmp++; if ({sif.s_cyc, sif.s_stb} !== 2'b11) begin n_err++; $display("FAIL at_still_busy got=%b exp=11", {sif.s_cyc, sif.s_stb}); end
    mif.m_cyc = '0; mif.m_stb = '0;
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL at_release got=%b exp=0000", mif.gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mif.m_cyc = 4'b0100; mif.m_stb = 4'b0100;
    tick(); sif.s_ack = 1'b1;
    tick(); sif.s_ack = 1'b0; mif.m_cyc = '0; mif.m_stb = '0;
    tick(); mif.m_cyc = 4'b1001; mif.m_stb = 4'b1001;
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b1000) begin n_err++; $display("FAIL rm_pre_gnt got=%b exp=1000", mif.gnt); end
    sif.s_ack = 1'b1; rst = 1'b1;
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0000) begin n_err++; $display("FAIL rm_gnt got=%b exp=0000", mif.gnt); end
    n_cmp++; if (sif.s_cyc !== 1'b0) begin n_err++; $display("FAIL rm_s_cyc got=%b exp=0", sif.s_cyc); end
    n_cmp++; if (mif.m_ack !== 4'b0000) begin n_err++; $display("FAIL rm_ack got=%b exp=0000", mif.m_ack); end
    sif.s_ack = 1'b0; rst = 1'b0;
    tick(); #1;
    n_cmp++; if (mif.gnt !== 4'b0001) begin n_err++; $display("FAIL rm_first got=%b exp=0001", mif.gnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_four();
    test_alternate();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
